// File: rtl/dmni_mmr_bank_if.sv
// Config, broadcast-receive and channel-control signals of the DMNI register bank.
// The slave modport is the register bank; the master modport is the processor/DMA side.
interface dmni_mmr_bank_if #(
    parameter int N_CH = 2
) ();
    localparam int AW = $clog2(6 + 2 * N_CH);

    logic                   cfg_en_i;
    logic                   cfg_we_i;
    logic [AW-1:0]          cfg_addr_i;
    logic [31:0]            cfg_data_i;
    logic [31:0]            cfg_data_o;
    logic                   br_valid_i;
    logic                   br_ready_o;
    logic [3:0]             br_ksvc_i;
    logic [15:0]            br_seq_source_i;
    logic [15:0]            br_payload_i;
    logic [N_CH-1:0]        ch_start_o;
    logic [32*N_CH-1:0]     ch_size_o;
    logic [32*N_CH-1:0]     ch_addr_o;
    logic [N_CH-1:0]        ch_done_i;
    logic                   irq_o;

    modport slave (
        input  cfg_en_i, cfg_we_i, cfg_addr_i, cfg_data_i,
        input  br_valid_i, br_ksvc_i, br_seq_source_i, br_payload_i,
        input  ch_done_i,
        output cfg_data_o, br_ready_o, ch_start_o, ch_size_o, ch_addr_o, irq_o
    );

    modport master (
        output cfg_en_i, cfg_we_i, cfg_addr_i, cfg_data_i,
        output br_valid_i, br_ksvc_i, br_seq_source_i, br_payload_i,
        output ch_done_i,
        input  cfg_data_o, br_ready_o, ch_start_o, ch_size_o, ch_addr_o, irq_o
    );
endinterface

// File: rtl/dmni_mmr_bank.sv
// DMNI memory-mapped register bank: N_CH Hermes DMA channel registers, BR receive FIFO, maskable IRQ.
// Define DMNI_RCV_TIMESTAMP_EN to add the receive-timestamp counter and per-entry timestamp storage.
module dmni_mmr_bank #(
    parameter int N_CH     = 2,
    parameter int BR_DEPTH = 4,
    parameter int TS_WIDTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    dmni_mmr_bank_if.slave  bus
);
    localparam int PW = $clog2(BR_DEPTH);

    logic [3:0]      ksvc_mem [BR_DEPTH];
    logic [31:0]     data_mem [BR_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] start_r;
    logic [N_CH:0]   pend;
    logic [N_CH:0]   mask;
    logic [31:0]     size_r [N_CH];
    logic [31:0]     addr_r [N_CH];
    logic [31:0]     rdata;
    logic [31:0]     rdata_q;
    logic            irq_q;
`ifdef DMNI_RCV_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_mem [BR_DEPTH];
`endif

    logic [31:0]     a_idx;
    logic            rd_fire;
    logic            wr_fire;
    logic            fifo_nempty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [N_CH-1:0] done_set;
    logic [N_CH:0]   pend_w1c;

    assign a_idx       = 32'(bus.cfg_addr_i);
    assign rd_fire     = bus.cfg_en_i & ~bus.cfg_we_i;
    assign wr_fire     = bus.cfg_en_i & bus.cfg_we_i;
    assign fifo_nempty = (count != '0);
    assign fifo_full   = (count == (PW+1)'(BR_DEPTH));
    assign push        = bus.br_valid_i & ~fifo_full;
    assign pop         = rd_fire & (a_idx == 32'd4) & fifo_nempty;
    assign done_set    = bus.ch_done_i & busy;
    assign pend_w1c    = (wr_fire && a_idx == 32'd1) ? bus.cfg_data_i[N_CH:0] : '0;

    assign bus.br_ready_o = ~fifo_full;
    assign bus.cfg_data_o = rdata_q;
    assign bus.irq_o      = irq_q;
    assign bus.ch_start_o = start_r;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch_out
        assign bus.ch_size_o[32*k +: 32] = size_r[k];
        assign bus.ch_addr_o[32*k +: 32] = addr_r[k];
    end

    // Head-of-FIFO fields read as zero when the FIFO is empty.
    always_comb begin
        rdata = '0;
        case (a_idx)
            32'd0: rdata = 32'({busy, fifo_full, fifo_nempty});
            32'd1: rdata = 32'(pend);
            32'd2: rdata = 32'(mask);
            32'd3: if (fifo_nempty) rdata = 32'(ksvc_mem[rd_ptr]);
            32'd4: if (fifo_nempty) rdata = data_mem[rd_ptr];
`ifdef DMNI_RCV_TIMESTAMP_EN
            32'd5: if (fifo_nempty) rdata = 32'(ts_mem[rd_ptr]);
`endif
            default: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (a_idx == 32'(6 + 2 * k)) rdata = size_r[k];
                    if (a_idx == 32'(7 + 2 * k)) rdata = addr_r[k];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
            pend    <= '0;
            mask    <= '0;
        end else begin
            if (rd_fire) rdata_q <= rdata;
            irq_q <= |(pend & mask);
            // New events win over a same-cycle W1C of the same bit.
            pend  <= (pend & ~pend_w1c) | {done_set, push};
            if (wr_fire && a_idx == 32'd2) mask <= bus.cfg_data_i[N_CH:0];
        end
    end

    // A busy channel ignores all writes to its size/address registers until done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy    <= '0;
            start_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                size_r[k] <= '0;
                addr_r[k] <= '0;
            end
        end else begin
            start_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (busy[k]) begin
                    if (bus.ch_done_i[k]) busy[k] <= 1'b0;
                end else if (wr_fire && a_idx == 32'(6 + 2 * k)) begin
                    size_r[k] <= bus.cfg_data_i;
                    if (bus.cfg_data_i != '0) begin
                        busy[k]    <= 1'b1;
                        start_r[k] <= 1'b1;
                    end
                end else if (wr_fire && a_idx == 32'(7 + 2 * k)) begin
                    addr_r[k] <= bus.cfg_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BR_DEPTH; i++) begin
                ksvc_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                ksvc_mem[wr_ptr] <= bus.br_ksvc_i;
                data_mem[wr_ptr] <= {bus.br_seq_source_i, bus.br_payload_i};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DMNI_RCV_TIMESTAMP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt <= '0;
            for (int i = 0; i < BR_DEPTH; i++) ts_mem[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (push) ts_mem[wr_ptr] <= ts_cnt;
        end
    end
`endif
endmodule
